rf_dump: RTL

Debug/readback engine on the read side of the 32x32 register file. On a start pulse it walks a contiguous index range through the file's two asynchronous read ports, two registers per fetch. It then streams each value with its index over a valid/ready output. It is used by the test harness and debug path to snapshot architectural state without touching the write port.

---
 rtl/rf_dump.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rf_dump.sv
// Register-file readback engine: fetches two registers per cycle over the file's
// asynchronous read ports and streams {index, value} words over a valid/ready port.
module rf_dump #(
    parameter int NREG = 32,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   first,
    input  logic [4:0]   last,
    output logic [4:0]   rA,
    output logic [4:0]   rB,
    input  logic [W-1:0] busA,
    input  logic [W-1:0] busB,
    output logic [W-1:0] out_data,
    output logic [4:0]   out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [4:0]   last_q, last_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         two_q, two_d;
    logic         head_q, head_d;
    logic         err_q, err_d;
    logic [4:0]   ra_q, ra_d;
    logic [4:0]   rb_q, rb_d;
    logic [4:0]   head_idx;
    logic         pop;
    logic         bad_range;

    // Output handshake: a word transfers on a cycle where out_valid && out_ready;
    // while out_valid is high and not accepted, out_data/out_idx are held unchanged.
    assign pop       = (state_q == S_SEND) && out_ready;
    assign head_idx  = idx_q + {4'd0, head_q};
    assign bad_range = (first > last) || ({27'd0, last} >= 32'(NREG));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        two_d   = two_q;
        head_d  = head_q;
        err_d   = err_q;
        ra_d    = 5'd0;
        rb_d    = 5'd0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (start) begin
                    last_d = last;
                    if (bad_range) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = first;
                        ra_d    = first;
                        rb_d    = first + 5'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                slot0_d = busA;
                if (idx_q != last_q) slot1_d = busB;
                two_d   = (idx_q != last_q);
                head_d  = 1'b0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (pop) begin
                    // Compare against last before advancing so last=31 never wraps.
                    if (!head_q && two_q) begin
                        head_d = 1'b1;
                    end else if (head_idx == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd2;
                        ra_d    = idx_q + 5'd2;
                        rb_d    = idx_q + 5'd3;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            last_q  <= 5'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            two_q   <= 1'b0;
            head_q  <= 1'b0;
            err_q   <= 1'b0;
            ra_q    <= 5'd0;
            rb_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            two_q   <= two_d;
            head_q  <= head_d;
            err_q   <= err_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
        end
    end

    assign rA          = ra_q;
    assign rB          = rb_q;
    assign out_valid   = (state_q == S_SEND);
    assign out_data    = head_q ? slot1_q : slot0_q;
    assign out_idx     = head_idx;
    assign busy        = (state_q == S_FETCH) || (state_q == S_SEND);
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_DONE) && err_q;
    assign dbg_state_o = state_q;

endmodule
